pattern_match_sched: RTL and testbench
======================================

Name: pattern_match_sched

Overview:
- Round-robin scheduler that shares one serial pattern-match engine among NREQ bit-stream requesters.
- Grants the engine to one requester per burst, then shifts that requester's bits through a PAT_W-bit window.
- Flags each occurrence of PATTERN, overlapping occurrences included.
- Reports a per-burst summary (match count, abort/overrun status) to the block's control layer.

Parameters:
NREQ, 4, number of requesters (2..8)
PAT_W, 4, pattern length in bits
PATTERN, 4'b1011, pattern matched; MSB is the oldest bit
MAX_BITS, 64, maximum bits per burst before forced termination
CNT_W, 8, width of per-burst match counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
req  in  NREQ  per-requester burst request; held high for the whole burst
din  in  NREQ  per-requester serial data bit; only the granted lane is sampled
last  in  NREQ  per-requester end-of-burst marker, qualifies the same-cycle din bit
gnt  out  NREQ  one-hot grant, registered
busy  out  1  engine owned by a requester
match  out  1  one-cycle pulse, pattern completed on the previous sampled bit
match_id  out  $clog2(NREQ)  requester index for match
done  out  1  one-cycle burst-complete pulse
done_id  out  $clog2(NREQ)  requester index for done
match_cnt  out  CNT_W  matches in finished burst; valid with done
aborted  out  1  valid with done: requester dropped req mid-burst
overrun  out  1  valid with done: MAX_BITS reached without last

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset values: state=IDLE, rr_ptr=0, all outputs 0.
- Reset mid-burst returns to IDLE immediately. No done is issued for the interrupted burst.
- IDLE:
  - Search req starting at rr_ptr, wrapping modulo NREQ.
  - First set bit wins. Load cur_id and set gnt[cur_id] on the same clock edge. Go to BUSY.
  - Window, bit counter and match counter clear on grant.
  - No req: stay in IDLE.
- Grant latency: req rising in IDLE gives gnt high on the next edge.
- The requester drives its first bit on the first cycle gnt is seen high.
- BUSY, each cycle:
  - Sample din[cur_id] and last[cur_id].
  - window <= {window[PAT_W-2:0], din}.
  - bits_seen increments, saturating at MAX_BITS.
  - A match occurs when bits_seen (including this bit) >= PAT_W and the new window == PATTERN.
  - On a match, register match=1 and match_id=cur_id for the next cycle, and increment match_cnt, saturating at 2^CNT_W-1.
  - Overlap is allowed: no window flush after a match.
- BUSY exit conditions, in priority order:
  1. req[cur_id]==0: aborted=1 and the din bit is not sampled.
  2. last[cur_id]==1: the bit is sampled normally, a match on it counts, then exit.
  3. bits_seen reaches MAX_BITS: overrun=1 after the bit is sampled.
  - On exit: go to DONE, gnt drops to 0 on the same edge.
- DONE (exactly one cycle):
  - done=1, done_id=cur_id. match_cnt, aborted and overrun are held stable.
  - rr_ptr <= (cur_id+1) mod NREQ. Go to IDLE.
  - Minimum gap between grants is 2 cycles (DONE, then IDLE arbitration).
- match and done are single-cycle pulses. match may be high in the same cycle as done when the last bit completes a pattern.
- Bursts shorter than PAT_W bits report match_cnt=0.
- A requester lowering req while not granted has no effect. Non-granted lanes' din and last are ignored.
- busy=1 in BUSY and DONE, 0 in IDLE.

Test Plan:
- Req0 only, bits 1,0,1,1 with last on the 4th bit -> gnt=0001 one cycle after req, match pulse with match_id=0, then done with match_cnt=1, aborted=0, overrun=0.
- Req2, bits 1,0,1,1,0,1,1 (last on the 7th) -> two match pulses, 3 cycles apart; done_id=2, match_cnt=2.
- req=1111 held continuously, 2-bit bursts each -> grant order 0,1,2,3,0, each grant separated by DONE+IDLE; match_cnt=0 every burst.
- Req1 streaming all-ones, no last -> overrun=1 with done after exactly 64 sampled bits; rr_ptr advances to 2.
- Req3 drops req after 3 bits (1,0,1) -> done with aborted=1, match_cnt=0; the next requester is granted from IDLE.
- reset asserted mid-burst after 1,0,1 -> gnt=0, busy=0 immediately, no done; the first grant after release goes to the lowest set req starting from index 0.

Source files
------------

// File: rtl/pattern_match_sched.sv
// Round-robin scheduler sharing one serial pattern-match engine among NREQ
// bit-stream requesters; reports a per-burst match count and exit status.
module pattern_match_sched #(
  parameter int              NREQ     = 4,
  parameter int              PAT_W    = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int              MAX_BITS = 64,
  parameter int              CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          din,
  input  logic [NREQ-1:0]          last,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     match,
  output logic [$clog2(NREQ)-1:0]  match_id,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     aborted,
  output logic                     overrun
);

  localparam int ID_W = $clog2(NREQ);
  localparam int BW   = $clog2(MAX_BITS + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   cur_id;
  logic [PAT_W-2:0]  window;
  logic [BW-1:0]     bits_seen;

  logic              arb_found;
  logic [ID_W-1:0]   arb_sel;
  logic              lane_req;
  logic              lane_din;
  logic              lane_last;
  logic [PAT_W-1:0]  win_nxt;
  logic [BW-1:0]     bits_nxt;
  logic              hit;

  function automatic logic [BW-1:0] sat_bits(input logic [BW-1:0] v);
    return (v >= BW'(MAX_BITS)) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Two descending passes: the last assignment wins, so a requester at or
  // above rr_ptr beats any below it, and the lowest index wins within a pass.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j] && (ID_W'(j) < rr_ptr)) begin
        arb_found = 1'b1;
        arb_sel   = ID_W'(j);
      end
    end
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j] && (ID_W'(j) >= rr_ptr)) begin
        arb_found = 1'b1;
        arb_sel   = ID_W'(j);
      end
    end
  end

  always_comb begin
    lane_req  = req[cur_id];
    lane_din  = din[cur_id];
    lane_last = last[cur_id];
    win_nxt   = {window, lane_din};
    bits_nxt  = sat_bits(bits_seen);
    hit       = (bits_nxt >= BW'(PAT_W)) && (win_nxt == PATTERN);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      window    <= '0;
      bits_seen <= '0;
      gnt       <= '0;
      match     <= 1'b0;
      match_id  <= '0;
      done      <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
      aborted   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      match <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_found) begin
            cur_id    <= arb_sel;
            gnt       <= NREQ'(1) << arb_sel;
            window    <= '0;
            bits_seen <= '0;
            match_cnt <= '0;
            aborted   <= 1'b0;
            overrun   <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (!lane_req) begin
            aborted <= 1'b1;
            gnt     <= '0;
            done    <= 1'b1;
            done_id <= cur_id;
            state   <= DONE;
          end else begin
            window    <= win_nxt[PAT_W-2:0];
            bits_seen <= bits_nxt;
            if (hit) begin
              match     <= 1'b1;
              match_id  <= cur_id;
              match_cnt <= sat_cnt(match_cnt);
            end
            // last takes priority over the bit limit when both land together
            if (lane_last || (bits_nxt == BW'(MAX_BITS))) begin
              overrun <= !lane_last;
              gnt     <= '0;
              done    <= 1'b1;
              done_id <= cur_id;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          done   <= 1'b0;
          rr_ptr <= (cur_id == ID_W'(NREQ - 1)) ? '0 : cur_id + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_match_sched.sv
// Self-checking bench for pattern_match_sched: table-driven bursts with a
// scoreboard of expected match/done events, plus hand-written corner sequences.
module tb_pattern_match_sched;

  localparam int         NREQ = 4;
  localparam logic [3:0] PAT  = 4'b1011;

  logic            clk = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req, din, last;
  logic [NREQ-1:0] gnt;
  logic            busy, match, done, aborted, overrun;
  logic [1:0]      match_id, done_id;
  logic [7:0]      match_cnt;

  pattern_match_sched #(
    .NREQ(4), .PAT_W(4), .PATTERN(4'b1011), .MAX_BITS(64), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .last(last),
    .gnt(gnt), .busy(busy), .match(match), .match_id(match_id),
    .done(done), .done_id(done_id), .match_cnt(match_cnt),
    .aborted(aborted), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lane;
    logic [63:0] bits;      // bit i is the i-th bit sent
    int          n;
    bit          use_last;
    int          drop_at;   // index where req is dropped, -1 for never
    logic [3:0]  others;    // extra requesters held during the grant
    int          gap;       // expected cycles between the last two matches, 0 = skip
    int          exp_cnt;
    bit          exp_ab;
    bit          exp_ov;
  } burst_t;

  typedef struct {
    int id;
    int cnt;
    bit ab;
    bit ov;
  } done_t;

  int    match_q[$];
  done_t done_q[$];
  int    checks = 0;
  int    errors = 0;
  int    done_seen = 0;
  time   t_prev = 0, t_last = 0;
  done_t exp_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (match) begin
        t_prev = t_last;
        t_last = $time;
        if (match_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_match: got id %0d expected no match", match_id);
        end else begin
          check("match_id", match_id, match_q.pop_front());
        end
      end
      if (done) begin
        done_seen++;
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got id %0d expected no done", done_id);
        end else begin
          exp_d = done_q.pop_front();
          check("done_id", done_id, exp_d.id);
          check("match_cnt", match_cnt, exp_d.cnt);
          check("aborted", aborted, exp_d.ab);
          check("overrun", overrun, exp_d.ov);
        end
      end
    end
  end

  task automatic run_burst(input burst_t b);
    int         lat;
    int         start_done;
    int         waits;
    int         nb;
    bit         lost;
    logic [3:0] win;
    logic [3:0] oh;
    oh = 4'(1) << b.lane;
    start_done = done_seen;
    done_q.push_back('{b.lane, b.exp_cnt, b.exp_ab, b.exp_ov});
    req = b.others | oh;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (gnt == 0 && lat < 10);
    check("grant", gnt, oh);
    check("grant_latency", lat, 1);
    check("busy_on_grant", busy, 1);
    win  = '0;
    nb   = 0;
    lost = 0;
    for (int i = 0; i < b.n; i++) begin
      din  = 4'($urandom);
      last = 4'($urandom);
      if (i == b.drop_at) begin
        req[b.lane]  = 1'b0;
        din[b.lane]  = 1'b1;
        last[b.lane] = 1'b0;
      end else begin
        din[b.lane]  = b.bits[i];
        last[b.lane] = b.use_last && (i == b.n - 1);
      end
      if (gnt != oh) lost = 1;
      @(posedge clk); #1;
      if (i == b.drop_at) break;
      win = {win[2:0], b.bits[i]};
      nb++;
      if (nb >= 4 && win == PAT) match_q.push_back(b.lane);
    end
    check("no_early_exit", lost, 0);
    check("gnt_drop_on_exit", gnt, 0);
    check("busy_in_done", busy, 1);
    req  = '0;
    last = '0;
    din  = '0;
    waits = 0;
    while (done_seen == start_done && waits < 10) begin
      @(negedge clk); #1;
      waits++;
    end
    check("done_timing", waits, 1);
    if (b.gap > 0) check("match_gap", (t_last - t_prev) / 10, b.gap);
    @(posedge clk); #1;
  endtask

  burst_t tbl[6];
  burst_t post_reset;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int start_done;
    logic [3:0] oh;

    tbl[0] = '{0, 64'b1101,    4, 1'b1, -1, 4'b0000, 0, 1, 1'b0, 1'b0};
    tbl[1] = '{2, 64'b1101101, 7, 1'b1, -1, 4'b0000, 3, 2, 1'b0, 1'b0};
    tbl[2] = '{1, {64{1'b1}},  64, 1'b0, -1, 4'b0000, 0, 0, 1'b0, 1'b1};
    tbl[3] = '{2, 64'b11,      2, 1'b1, -1, 4'b1011, 0, 0, 1'b0, 1'b0};
    tbl[4] = '{3, 64'b101,     4, 1'b0,  3, 4'b0001, 0, 0, 1'b1, 1'b0};
    tbl[5] = '{0, 64'b101,     3, 1'b1, -1, 4'b0000, 0, 0, 1'b0, 1'b0};
    post_reset = '{0, 64'b11,  2, 1'b1, -1, 4'b0100, 0, 0, 1'b0, 1'b0};

    reset = 1'b1;
    req   = '0;
    din   = '0;
    last  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_match", match, 0);
    check("rst_done", done, 0);
    check("rst_ids", {match_id, done_id}, 0);
    check("rst_status", {match_cnt, aborted, overrun}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_no_req_gnt", gnt, 0);

    // All four requesting continuously: expect 0,1,2,3,0 with two-cycle gaps.
    start_done = done_seen;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'(1) << (k % 4);
      done_q.push_back('{k % 4, 0, 1'b0, 1'b0});
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
      end while (gnt == 0 && lat < 10);
      check("rr_grant", gnt, oh);
      check("rr_latency", lat, (k == 0) ? 1 : 2);
      for (int i = 0; i < 2; i++) begin
        din  = 4'($urandom);
        last = 4'($urandom) & ~oh;
        din  = din | oh;
        if (i == 1) last = last | oh;
        @(posedge clk); #1;
      end
      check("rr_gnt_drop", gnt, 0);
    end
    req  = '0;
    last = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rr_done_count", done_seen - start_done, 5);

    for (int t = 0; t < 6; t++) run_burst(tbl[t]);

    // Reset in the middle of a burst on lane 2, after bits 1,0,1.
    req = 4'b0100;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (gnt == 0 && lat < 10);
    check("pre_reset_grant", gnt, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      din  = '0;
      din[2] = (i != 1);
      @(posedge clk); #1;
    end
    start_done = done_seen;
    reset = 1'b1;
    #1;
    check("mid_reset_gnt", gnt, 0);
    check("mid_reset_busy", busy, 0);
    req = '0;
    din = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("no_done_after_reset", done_seen - start_done, 0);
    run_burst(post_reset);
    check("post_reset_done_count", done_seen - start_done, 1);

    repeat (3) @(posedge clk);
    #1;
    check("match_q_empty", match_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
